// File: rtl/ddr4_cmd_arbiter_if.sv
// Bundle of requester, refresh and command-channel signals for ddr4_cmd_arbiter.
// slave = arbiter side, master = the environment driving requests and accepting commands.
interface ddr4_cmd_arbiter_if #(
  parameter int ROW_WIDTH  = 12,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 3
);
  localparam int ADDR_WIDTH = ROW_WIDTH + BANK_WIDTH + COL_WIDTH;

  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;
  logic                  ref_req;
  logic                  ref_ack;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_type;
  logic [BANK_WIDTH-1:0] cmd_bank;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic [COL_WIDTH-1:0]  cmd_col;
  logic                  cmd_src;
  logic                  busy;
  logic [3:0]            dbg_state;

  modport slave (
    input  req0_valid, req0_write, req0_addr,
    input  req1_valid, req1_write, req1_addr,
    input  ref_req, cmd_ready,
    output req0_ready, req1_ready, ref_ack,
    output cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_src,
    output busy, dbg_state
  );

  modport master (
    output req0_valid, req0_write, req0_addr,
    output req1_valid, req1_write, req1_addr,
    output ref_req, cmd_ready,
    input  req0_ready, req1_ready, ref_ack,
    input  cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_src,
    input  busy, dbg_state
  );
endinterface

// File: rtl/ddr4_cmd_arbiter.sv
// Two-requester DDR4 command arbiter: round-robin grant, open-page row tracking,
// PRE/ACT/RD/WR sequencing with tRP/tRCD spacing, and PREA+REF refresh handling.
module ddr4_cmd_arbiter #(
  parameter int ROW_WIDTH  = 12,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 3,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RFC      = 16
) (
  input  logic                clk,
  input  logic                reset,
  ddr4_cmd_arbiter_if.slave   bus
);
  localparam int ADDR_WIDTH = ROW_WIDTH + BANK_WIDTH + COL_WIDTH;
  localparam int NUM_BANKS  = 1 << BANK_WIDTH;

  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  // Wait states exit when the counter reaches 1, so loading T-1 puts the next
  // command exactly T cycles after the handshake cycle.
  localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
  localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 1);
  localparam logic [7:0] RFC_LOAD = 8'(T_RFC);

  typedef enum logic [3:0] {
    S_ARB, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT,
    S_RW, S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  src_q, src_d;
  logic                  last_q, last_d;
  logic [NUM_BANKS-1:0]  open_q, open_d;
  logic [ROW_WIDTH-1:0]  row_q [NUM_BANKS];
  logic [ROW_WIDTH-1:0]  row_d [NUM_BANKS];

  logic                  gnt_any, gnt_src;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ROW_WIDTH-1:0]  sel_row, a_row;
  logic [BANK_WIDTH-1:0] sel_bank, a_bank;
  logic [COL_WIDTH-1:0]  a_col;

  // Handshake: a command transfers in the cycle cmd_valid && cmd_ready; while
  // cmd_ready is low, cmd_valid and every cmd_* field hold and no table update occurs.
  // A request transfers in the cycle reqN_valid && reqN_ready.
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt_src = ~last_q;
    else                                  gnt_src = bus.req1_valid;
    sel_addr = gnt_src ? bus.req1_addr : bus.req0_addr;
    sel_row  = sel_addr[ADDR_WIDTH-1 -: ROW_WIDTH];
    sel_bank = sel_addr[COL_WIDTH +: BANK_WIDTH];
    a_row    = addr_q[ADDR_WIDTH-1 -: ROW_WIDTH];
    a_bank   = addr_q[COL_WIDTH +: BANK_WIDTH];
    a_col    = addr_q[COL_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    src_d   = src_q;
    last_d  = last_q;
    open_d  = open_q;
    row_d   = row_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.ref_ack    = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = 3'd0;
    bus.cmd_bank   = '0;
    bus.cmd_row    = '0;
    bus.cmd_col    = '0;
    bus.cmd_src    = 1'b0;

    case (state_q)
      S_ARB: begin
        if (bus.ref_req) begin
          state_d = (|open_q) ? S_PREA : S_REF;
        end else if (gnt_any) begin
          bus.req0_ready = ~gnt_src;
          bus.req1_ready = gnt_src;
          addr_d  = sel_addr;
          write_d = gnt_src ? bus.req1_write : bus.req0_write;
          src_d   = gnt_src;
          last_d  = gnt_src;
          if (open_q[sel_bank] && row_q[sel_bank] == sel_row) state_d = S_RW;
          else if (open_q[sel_bank])                          state_d = S_PRE;
          else                                                state_d = S_ACT;
        end
      end
      S_PRE: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = CMD_PRE;
        bus.cmd_bank  = a_bank;
        bus.cmd_src   = src_q;
        if (bus.cmd_ready) begin
          open_d[a_bank] = 1'b0;
          cnt_d   = RP_LOAD;
          state_d = S_PRE_WAIT;
        end
      end
      S_PRE_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_ACT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ACT: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = CMD_ACT;
        bus.cmd_bank  = a_bank;
        bus.cmd_row   = a_row;
        bus.cmd_src   = src_q;
        if (bus.cmd_ready) begin
          open_d[a_bank] = 1'b1;
          row_d[a_bank]  = a_row;
          cnt_d   = RCD_LOAD;
          state_d = S_ACT_WAIT;
        end
      end
      S_ACT_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_RW;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_RW: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = write_q ? CMD_WR : CMD_RD;
        bus.cmd_bank  = a_bank;
        bus.cmd_col   = a_col;
        bus.cmd_src   = src_q;
        if (bus.cmd_ready) state_d = S_ARB;
      end
      S_PREA: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = CMD_PREA;
        if (bus.cmd_ready) begin
          open_d  = '0;
          cnt_d   = RP_LOAD;
          state_d = S_PREA_WAIT;
        end
      end
      S_PREA_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_REF;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_REF: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = CMD_REF;
        if (bus.cmd_ready) begin
          bus.ref_ack = 1'b1;
          cnt_d   = RFC_LOAD;
          state_d = S_REF_WAIT;
        end
      end
      S_REF_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_ARB;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_ARB;
    endcase
  end

  assign bus.busy      = (state_q != S_ARB);
  assign bus.dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ARB;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      open_q  <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      src_q   <= src_d;
      last_q  <= last_d;
      open_q  <= open_d;
      row_q   <= row_d;
    end
  end
endmodule

// File: tb/tb_ddr4_cmd_arbiter.sv
// Directed bench for ddr4_cmd_arbiter with default timing (tRCD=4, tRP=4, tRFC=16).
module tb_ddr4_cmd_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ddr4_cmd_arbiter_if #(.ROW_WIDTH(12), .BANK_WIDTH(2), .COL_WIDTH(3)) bus();

  ddr4_cmd_arbiter #(
    .ROW_WIDTH(12), .BANK_WIDTH(2), .COL_WIDTH(3),
    .T_RCD(4), .T_RP(4), .T_RFC(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [16:0] mk(input logic [11:0] row, input logic [1:0] bank,
                                     input logic [2:0] col);
    mk = {row, bank, col};
  endfunction

  task automatic expect_cmd(input string tag, input logic [2:0] t, input logic [1:0] b,
                            input logic [11:0] r, input logic [2:0] c, input logic s);
    check({tag, "_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
    check({tag, "_type"},  {29'd0, bus.cmd_type}, {29'd0, t});
    check({tag, "_bank"},  {30'd0, bus.cmd_bank}, {30'd0, b});
    check({tag, "_row"},   {20'd0, bus.cmd_row},  {20'd0, r});
    check({tag, "_col"},   {29'd0, bus.cmd_col},  {29'd0, c});
    check({tag, "_src"},   {31'd0, bus.cmd_src},  {31'd0, s});
  endtask

  task automatic idle_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_idle"}, {31'd0, bus.cmd_valid}, 32'd0);
    end
  endtask

  // Present a request in an ARB cycle, confirm the grant, and advance past acceptance.
  task automatic issue(input string tag, input logic who, input logic wr, input logic [16:0] a);
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = a;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = a;
    end
    #1;
    check({tag, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, who ? 32'd2 : 32'd1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rw(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_valid && (bus.cmd_type == 3'd2 || bus.cmd_type == 3'd3)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_rw_timeout"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_grant(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        found = 1'b1;
        break;
      end
      step();
      #1;
    end
    check({tag, "_gnt_timeout"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0;
    bus.ref_req = 1'b0;
    bus.cmd_ready = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_ack",   {31'd0, bus.ref_ack}, 32'd0);
    check("rst_type",  {29'd0, bus.cmd_type}, 32'd0);
    check("rst_row",   {20'd0, bus.cmd_row}, 32'd0);
    reset = 1'b0;

    // Cold miss: ACT at t+1, WR at t+5.
    issue("cold", 1'b0, 1'b1, mk(12'd5, 2'd2, 3'd3));
    expect_cmd("cold_act", 3'd1, 2'd2, 12'd5, 3'd0, 1'b0);
    idle_for("cold_rcd", 3);
    step();
    expect_cmd("cold_wr", 3'd3, 2'd2, 12'd0, 3'd3, 1'b0);
    step();
    check("cold_busy_done", {31'd0, bus.busy}, 32'd0);

    // Page hit: RD directly at accept+1.
    issue("hit", 1'b0, 1'b0, mk(12'd5, 2'd2, 3'd1));
    expect_cmd("hit_rd", 3'd2, 2'd2, 12'd0, 3'd1, 1'b0);
    step();

    // Row conflict: PRE, ACT 4 cycles later, RD 4 cycles after that.
    issue("conf", 1'b0, 1'b0, mk(12'd7, 2'd2, 3'd4));
    expect_cmd("conf_pre", 3'd4, 2'd2, 12'd0, 3'd0, 1'b0);
    idle_for("conf_rp", 3);
    step();
    expect_cmd("conf_act", 3'd1, 2'd2, 12'd7, 3'd0, 1'b0);
    idle_for("conf_rcd", 3);
    step();
    expect_cmd("conf_rd", 3'd2, 2'd2, 12'd0, 3'd4, 1'b0);
    step();

    // Fairness from a fresh reset: grants alternate starting with req0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k % 2));
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = mk(12'd5, 2'd2, 3'd1);
    bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = mk(12'd5, 2'd2, 3'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      wait_grant("fair");
      check("fair_gnt", {30'd0, bus.req1_ready, bus.req0_ready}, e[0] ? 32'd2 : 32'd1);
      step();
      wait_rw("fair");
      check("fair_src",  {31'd0, bus.cmd_src}, e);
      check("fair_type", {29'd0, bus.cmd_type}, e[0] ? 32'd3 : 32'd2);
      check("fair_col",  {29'd0, bus.cmd_col}, e[0] ? 32'd2 : 32'd1);
      step();
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("fair_left", exp_q.size(), 32'd0);

    // Refresh with bank2 open, req1 raised together with ref_req.
    bus.ref_req = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = mk(12'd5, 2'd2, 3'd6);
    #1;
    check("ref_block_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    step();
    expect_cmd("ref_prea", 3'd5, 2'd0, 12'd0, 3'd0, 1'b0);
    check("ref_ack_prea", {31'd0, bus.ref_ack}, 32'd0);
    idle_for("ref_rp", 3);
    step();
    expect_cmd("ref_ref", 3'd6, 2'd0, 12'd0, 3'd0, 1'b0);
    check("ref_ack_pulse", {31'd0, bus.ref_ack}, 32'd1);
    bus.ref_req = 1'b0;
    idle_for("ref_rfc", 16);
    check("ref_wait_busy", {31'd0, bus.busy}, 32'd1);
    step();
    #1;
    check("ref_req1_gnt", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    step();
    bus.req1_valid = 1'b0;
    expect_cmd("ref_req1_act", 3'd1, 2'd2, 12'd5, 3'd0, 1'b1);
    wait_rw("ref_req1");
    check("ref_req1_col", {29'd0, bus.cmd_col}, 32'd6);
    step();

    // Backpressure on ACT for 10 cycles, then on a page-hit RD for 2 cycles.
    issue("bp", 1'b0, 1'b0, mk(12'd9, 2'd1, 3'd0));
    bus.cmd_ready = 1'b0;
    expect_cmd("bp_act0", 3'd1, 2'd1, 12'd9, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_cmd("bp_hold", 3'd1, 2'd1, 12'd9, 3'd0, 1'b0);
    end
    bus.cmd_ready = 1'b1;
    idle_for("bp_rcd", 3);
    step();
    expect_cmd("bp_rd", 3'd2, 2'd1, 12'd0, 3'd0, 1'b0);
    step();
    issue("bp_hit", 1'b0, 1'b0, mk(12'd9, 2'd1, 3'd5));
    bus.cmd_ready = 1'b0;
    step();
    expect_cmd("bp_hit_hold", 3'd2, 2'd1, 12'd0, 3'd5, 1'b0);
    bus.cmd_ready = 1'b1;
    step();
    check("bp_hit_done", {31'd0, bus.busy}, 32'd0);

    // Reset in ACT_WAIT abandons the sequence; bank stays closed afterwards.
    issue("rstm", 1'b0, 1'b0, mk(12'd3, 2'd0, 3'd2));
    expect_cmd("rstm_act", 3'd1, 2'd0, 12'd3, 3'd0, 1'b0);
    step();
    check("rstm_wait_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstm_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rstm_busy",  {31'd0, bus.busy}, 32'd0);
    issue("rstm_again", 1'b0, 1'b0, mk(12'd3, 2'd0, 3'd2));
    expect_cmd("rstm_act2", 3'd1, 2'd0, 12'd3, 3'd0, 1'b0);
    wait_rw("rstm");
    check("rstm_col", {29'd0, bus.cmd_col}, 32'd2);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
